// File: rtl/decoder_2to4.sv
// ----------------------------------------------------------------------------
// decoder_2to4
//
// Registered 2-to-4 binary decoder. A 2-bit select code is converted into a
// 4-bit one-hot word (one-cold when ACTIVE_LOW=1) and captured on the rising
// clock, so downstream logic sees a glitch-free value one cycle after the
// code is sampled. A new code may be applied every cycle.
//
// Parameters:
//   ACTIVE_LOW  0: asserted output bit is 1, idle level is 0000.
//               1: asserted output bit is 0, idle level is 1111.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (priority over en)
//   input_bits   binary select code
//   en           decode enable; when low both outputs hold
//   output_bits  registered decoded word
//   out_valid    high once output_bits holds a decode of a sampled code
// ----------------------------------------------------------------------------
module decoder_2to4 #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] input_bits,
   input  logic       en,
   output logic [3:0] output_bits,
   output logic       out_valid
);

   // Level of every output bit when nothing is asserted.
   localparam logic [3:0] IDLE_LEVEL = ACTIVE_LOW ? 4'b1111 : 4'b0000;

   logic [3:0] one_hot;
   logic       code_known;
   logic [3:0] next_bits;

   // The default arm only matters for an unknown select code in simulation:
   // it yields the idle level and marks the result invalid. For synthesis
   // the four explicit arms already cover every code.
   always_comb begin
      one_hot    = '0;
      code_known = 1'b1;
      case (input_bits)
         2'b00:   one_hot = 4'b0001;
         2'b01:   one_hot = 4'b0010;
         2'b10:   one_hot = 4'b0100;
         2'b11:   one_hot = 4'b1000;
         default: begin
            one_hot    = '0;
            code_known = 1'b0;
         end
      endcase
   end

   always_comb begin
      next_bits = IDLE_LEVEL;
      if (code_known) begin
         next_bits = ACTIVE_LOW ? ~one_hot : one_hot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         output_bits <= IDLE_LEVEL;
         out_valid   <= 1'b0;
      end else if (en) begin
         output_bits <= next_bits;
         out_valid   <= code_known;
      end
   end

endmodule

// File: tb/tb_decoder_2to4.sv
// ----------------------------------------------------------------------------
// tb_decoder_2to4
//
// Self-checking bench for decoder_2to4. Two instances share all inputs: one
// with the default one-hot polarity and one with ACTIVE_LOW=1. Directed
// vectors cover reset, the code sweep, enable hold, reset mid-stream and
// polarity; a random phase compares against a 1-cycle-delayed model.
// ----------------------------------------------------------------------------
module tb_decoder_2to4;

   logic       clk;
   logic       rst;
   logic [1:0] input_bits;
   logic       en;
   logic [3:0] out_hi;
   logic       vld_hi;
   logic [3:0] out_lo;
   logic       vld_lo;

   int unsigned checks;
   int unsigned failures;

   decoder_2to4 #(.ACTIVE_LOW(1'b0)) dut_hi (
      .clk        (clk),
      .rst        (rst),
      .input_bits (input_bits),
      .en         (en),
      .output_bits(out_hi),
      .out_valid  (vld_hi)
   );

   decoder_2to4 #(.ACTIVE_LOW(1'b1)) dut_lo (
      .clk        (clk),
      .rst        (rst),
      .input_bits (input_bits),
      .en         (en),
      .output_bits(out_lo),
      .out_valid  (vld_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] hi,
                            input logic [3:0] lo, input logic vld);
      check({tag, "_hi"},     {4'h0, out_hi}, {4'h0, hi});
      check({tag, "_lo"},     {4'h0, out_lo}, {4'h0, lo});
      check({tag, "_vld_hi"}, {7'h0, vld_hi}, {7'h0, vld});
      check({tag, "_vld_lo"}, {7'h0, vld_lo}, {7'h0, vld});
   endtask

   logic [3:0] sweep_hi [4];
   logic [3:0] sweep_lo [4];
   logic [3:0] model;
   logic       model_vld;
   logic       rnd_en;
   logic [1:0] rnd_in;

   initial begin
      checks   = 0;
      failures = 0;
      sweep_hi = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      sweep_lo = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      rst        = 1'b1;
      en         = 1'b1;
      input_bits = 2'b11;

      // Reset for two edges; reset beats en and the select code.
      tick();
      check_all("reset1", 4'b0000, 4'b1111, 1'b0);
      tick();
      check_all("reset2", 4'b0000, 4'b1111, 1'b0);

      // Sweep all codes at full rate.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         input_bits = 2'(i);
         tick();
         check_all($sformatf("sweep%0d", i), sweep_hi[i], sweep_lo[i], 1'b1);
      end

      // Enable hold.
      input_bits = 2'b10;
      tick();
      check_all("hold_load", 4'b0100, 4'b1011, 1'b1);
      en         = 1'b0;
      input_bits = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all($sformatf("hold%0d", i), 4'b0100, 4'b1011, 1'b1);
      end
      en = 1'b1;
      tick();
      check_all("hold_release", 4'b0010, 4'b1101, 1'b1);

      // Reset mid-stream.
      input_bits = 2'b11;
      tick();
      check_all("mid_load", 4'b1000, 4'b0111, 1'b1);
      rst = 1'b1;
      tick();
      check_all("mid_reset", 4'b0000, 4'b1111, 1'b0);
      rst        = 1'b0;
      input_bits = 2'b01;
      tick();
      check_all("mid_resume", 4'b0010, 4'b1101, 1'b1);

      // Reset with en low still clears.
      en  = 1'b0;
      rst = 1'b1;
      tick();
      check_all("reset_en_low", 4'b0000, 4'b1111, 1'b0);

      // Polarity pair after reset.
      rst        = 1'b0;
      en         = 1'b1;
      input_bits = 2'b00;
      tick();
      check_all("pol_00", 4'b0001, 4'b1110, 1'b1);
      input_bits = 2'b11;
      tick();
      check_all("pol_11", 4'b1000, 4'b0111, 1'b1);

      // Random phase from a fresh reset against a delayed model.
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      model     = 4'b0000;
      model_vld = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         rnd_en     = 1'($urandom_range(0, 1));
         rnd_in     = 2'($urandom_range(0, 3));
         en         = rnd_en;
         input_bits = rnd_in;
         if (rnd_en) begin
            model     = 4'b0001 << rnd_in;
            model_vld = 1'b1;
         end
         tick();
         check("rnd_hi",  {4'h0, out_hi}, {4'h0, model});
         check("rnd_lo",  {4'h0, out_lo}, {4'h0, ~model});
         check("rnd_vld", {6'h0, vld_lo, vld_hi}, {6'h0, model_vld, model_vld});
         if (model_vld) begin
            check("rnd_ones_hi",  8'($countones(out_hi)), 8'd1);
            check("rnd_zeros_lo", 8'($countones(~out_lo)), 8'd1);
         end else begin
            check("rnd_none_hi", 8'($countones(out_hi)), 8'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decoder_2to4.md
Name: decoder_2to4

Overview:
Registered 2-to-4 one-hot binary decoder. It converts a 2-bit select code into a 4-bit one-hot word, for example for select/enable fan-out. The output is captured on the clock, so downstream logic sees a glitch-free registered value one cycle after the input. An optional enable gates updates, and a parameter selects output polarity.

Parameters:
- ACTIVE_LOW, default 0: 0 = asserted output bit is 1 (one-hot); 1 = asserted output bit is 0 (one-cold), and all idle/reset levels are inverted accordingly.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on rising clk only.
- input_bits  input  2  binary select code.
- en  input  1  decode enable; when low the outputs hold their value.
- output_bits  output  4  registered decoded word.
- out_valid  output  1  high when output_bits holds a decode of a sampled input.

Behaviour:
- Every output is driven from a flop; there is no combinational path from input to output.
- Reset: on a rising clk with rst=1:
  - output_bits <= 4'b0000 (4'b1111 if ACTIVE_LOW=1).
  - out_valid <= 0.
  - Reset has priority over en and input_bits.
- Decode: on a rising clk with rst=0 and en=1, output_bits <= one-hot of input_bits, with bit index = input_bits:
  - 00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.
  - If ACTIVE_LOW=1, the result is the bitwise inverse: 00 -> 1110, etc.
  - out_valid <= 1.
- Hold: on a rising clk with rst=0 and en=0, output_bits and out_valid keep their previous values.
- Latency: exactly 1 clock from sampled input_bits/en to output_bits. A new code can be applied every cycle at full throughput.
- Invariant: after the first enabled decode, output_bits always has exactly one asserted bit. Before that (after reset) it has none.
- Unknown/X on input_bits with en=1: output_bits <= all idle level (0000 / 1111) and out_valid <= 0. In synthesis this reduces to the normal case decode plus a default.
- Reset mid-stream: rst asserted in any cycle clears the outputs on that edge, regardless of en. Decoding resumes on the first edge with rst=0 and en=1.
- rst and en both high on the same edge: reset wins.
- No internal state beyond the output_bits and out_valid registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with input_bits=11, en=1 -> output_bits=0000, out_valid=0 after each edge.
- Sweep: rst=0, en=1; apply input_bits 00, 01, 10, 11 on consecutive cycles -> one cycle later output_bits = 0001, 0010, 0100, 1000; out_valid=1 from the first decode.
- Enable hold: decode 10 (output 0100), then en=0 and input_bits=01 for 3 cycles -> output_bits stays 0100 and out_valid stays 1; set en=1 -> 0010 on the next edge.
- Reset mid-operation: output 1000 with en=1; assert rst for one edge -> 0000 and out_valid=0; deassert with input 01 -> 0010 on the next edge.
- Polarity: with ACTIVE_LOW=1, reset -> 1111, then input 00 -> 1110 and input 11 -> 0111.
- One-hot check: random input_bits/en for 1000 cycles -> after the first enabled decode, $countones(output_bits)==1 (zeros for ACTIVE_LOW) every cycle, and output_bits matches a 1-cycle-delayed reference model.
